// File: rtl/umips_muldiv.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, 33-cycle latency.
module umips_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_prod_q, neg_prod_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend bits shift out of the low half as quotient bits shift in.
    assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, opb_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = neg_prod_q ? -acc_q : acc_q;
    assign quo_fix  = neg_prod_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divz_q     <= 1'b0;
            dvd_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            divz_q     <= divz_d;
            dvd_q      <= dvd_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        divz_d     = divz_q;
        dvd_d      = dvd_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_prod_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    divz_d     = op[1] & (b == '0);
                    dvd_d      = a;
                    if (op[1]) begin
                        opb_d = abs_b;
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        opb_d = abs_a;
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                    end
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = dvd_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_umips_muldiv.sv
// Self-checking bench for umips_muldiv: directed corner cases, randomized ops against an
// arithmetic reference model, MTHI/MTLO, ignored inputs while busy, async reset, back-to-back.
module tb_umips_muldiv;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  a, b, wd;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    umips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q  = sx / sy;
                    r  = sx % sy;
                    qv = 64'(q);
                    rv = 64'(r);
                    p  = {rv[31:0], qv[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    // Issues an op at the current negedge and follows it until done (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output int edges, output int busy_cnt, output bit stable);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        edges = 0;
        busy_cnt = busy ? 1 : 0;
        stable = 1'b1;
        while (!done && edges < 100) begin
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
        end
        rhi = hi;
        rlo = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [10] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd2, 2'd1};
        logic [31:0] t_a  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100,
                                   32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd7, 32'd0};
        logic [31:0] t_b  [10] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2, 32'd7,
                                   32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0001_2345};
        logic [31:0] t_hi [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2,
                                   32'd0, 32'd7, 32'hFFFF_FFF9, 32'd1, 32'd0};
        logic [31:0] t_lo [10] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'd0, 32'hFFFF_FFFD, 32'd14,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0};
        logic [31:0] rh, rl;
        int          e, bc;
        bit          st;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], rh, rl, e, bc, st);
            n_checks++; if (rh !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, rh, t_hi[i]); end
            n_checks++; if (rl !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, rl, t_lo[i]); end
            n_checks++; if (e != 33) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 33", i, e); end
            n_checks++; if (bc != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, bc); end
            n_checks++; if (!st) begin n_fail++; $display("FAIL dir%0d_hilo_stable got changed want stable", i); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, rh, rl;
        logic [63:0] exp;
        int          e, bc, sel;
        bit          st;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) y = 32'($urandom_range(1, 15));
            else if (sel == 2) x = 32'h8000_0000;
            exp = model(o, x, y);
            run_op(o, x, y, rh, rl, e, bc, st);
            n_checks++; if (rh !== exp[63:32]) begin n_fail++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, rh, exp[63:32]); end
            n_checks++; if (rl !== exp[31:0]) begin n_fail++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, rl, exp[31:0]); end
            n_checks++; if (e != 33) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 33", i, e); end
            n_checks++; if (!st) begin n_fail++; $display("FAIL rand%0d_hilo_stable got changed want stable", i); end
        end
    endtask

    task automatic test_mt();
        logic [31:0] l0, rh, rl;
        int          e, bc;
        bit          st;
        l0 = lo;
        hi_we = 1'b1; wd = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi got %h want 12345678", hi); end
        n_checks++; if (lo !== l0) begin n_fail++; $display("FAIL mthi_lo_kept got %h want %h", lo, l0); end
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_0F0F;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL mt_both_hi got %h want a5a50f0f", hi); end
        n_checks++; if (lo !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL mt_both_lo got %h want a5a50f0f", lo); end
        // Write strobes held from the start cycle through the run must not land.
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0000_DEAD;
        run_op(2'd1, 32'd2, 32'd3, rh, rl, e, bc, st);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (!st) begin n_fail++; $display("FAIL mt_while_busy got hi/lo changed want stable"); end
        n_checks++; if (rh !== 32'd0) begin n_fail++; $display("FAIL mt_busy_hi got %h want 0", rh); end
        n_checks++; if (rl !== 32'd6) begin n_fail++; $display("FAIL mt_busy_lo got %h want 6", rl); end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        logic [31:0] h0;
        int          e;
        h0 = hi;
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        repeat (5) begin @(negedge clk); e++; end
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9; hi_we = 1'b1; wd = 32'h0000_DEAD;
        @(negedge clk);
        e++;
        start = 1'b0; hi_we = 1'b0;
        n_checks++; if (hi !== h0) begin n_fail++; $display("FAIL ign_hi_we got %h want %h", hi, h0); end
        while (!done && e < 100) begin @(negedge clk); e++; end
        n_checks++; if (e != 33) begin n_fail++; $display("FAIL ign_latency got %0d want 33", e); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ign_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL ign_lo got %h want c", lo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_second_op got busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rh, rl;
        int          e, bc;
        bit          st;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0000_0055;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL arst_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL arst_lo got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'd3, 32'd42, 32'd6, rh, rl, e, bc, st);
        n_checks++; if (rl !== 32'd7) begin n_fail++; $display("FAIL arst_after_lo got %h want 7", rl); end
        n_checks++; if (rh !== 32'd0) begin n_fail++; $display("FAIL arst_after_hi got %h want 0", rh); end
        n_checks++; if (e != 33) begin n_fail++; $display("FAIL arst_after_latency got %0d want 33", e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2, rh, rl;
        logic [63:0] exp1, exp2;
        int          e, bc;
        bit          st;
        for (int i = 0; i < 3; i++) begin
            x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
            exp1 = model(2'd0, x1, y1);
            exp2 = model(2'd2, x2, y2);
            run_op(2'd0, x1, y1, rh, rl, e, bc, st);
            n_checks++; if ({rh, rl} !== exp1) begin n_fail++; $display("FAIL b2b%0d_first got %h want %h", i, {rh, rl}, exp1); end
            run_op(2'd2, x2, y2, rh, rl, e, bc, st);
            n_checks++; if ({rh, rl} !== exp2) begin n_fail++; $display("FAIL b2b%0d_second got %h want %h", i, {rh, rl}, exp2); end
            n_checks++; if (e != 33) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want 33", i, e); end
            n_checks++; if (bc != 33) begin n_fail++; $display("FAIL b2b%0d_busy_cycles got %0d want 33", i, bc); end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mt();
        test_ignore();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
